mult_16_seq: RTL and testbench



---
 rtl/mult_pkg.sv | 31 +++
 rtl/mult_16_seq_if.sv | 25 ++
 rtl/cla_add16.sv | 53 +++++
 rtl/mult_ctrl.sv | 93 +++++++++
 rtl/mult_16_seq.sv | 160 ++++++++++++++++
 tb/tb_mult_16_seq.sv | 250 +++++++++++++++++++++++++
 6 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the mult_16_seq sequential multiplier: operand
// width, iteration counter width, FSM state encoding and small arithmetic
// helpers. The optional signed mode is controlled by the MULT_SIGNED_EN macro.
package mult_pkg;

    localparam int MULT_W = 16;
    localparam int CNT_W  = 4;

    // Counter value loaded on start; RUN ends after the pass where cnt is 0,
    // giving exactly MULT_W iterations.
    localparam logic [CNT_W-1:0] ITER_LAST = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Magnitude of a two's complement operand. 0x8000 maps to 0x8000, which
    // is correct when the result is read back as unsigned.
    function automatic logic [MULT_W-1:0] abs_w(input logic [MULT_W-1:0] v);
        return v[MULT_W-1] ? (~v + 16'd1) : v;
    endfunction

    // Two's complement negation of a full-width product.
    function automatic logic [2*MULT_W-1:0] neg_2w(input logic [2*MULT_W-1:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/mult_16_seq_if.sv
// Request/result bundle between the control unit (master) and the
// multiplier (slave).
interface mult_16_seq_if;
    import mult_pkg::*;

    logic              start;
    logic              is_signed;
    logic [MULT_W-1:0] a;
    logic [MULT_W-1:0] b;
    logic              busy;
    logic              done;
    logic [MULT_W-1:0] hi;
    logic [MULT_W-1:0] lo;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/cla_add16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with group generate and
// propagate terms feeding a lookahead carry chain between groups.
module cla_add16
    import mult_pkg::*;
(
    input  logic [MULT_W-1:0] x,
    input  logic [MULT_W-1:0] y,
    input  logic              cin,
    output logic [MULT_W-1:0] sum,
    output logic              cout
);

    logic [MULT_W-1:0] g_s;
    logic [MULT_W-1:0] p_s;
    logic [MULT_W:0]   c_s;
    logic [3:0]        gg_s;
    logic [3:0]        gp_s;
    logic [4:0]        gc_s;

    // Bit and group generate/propagate, group carries, then per-bit carries.
    always_comb begin
        g_s  = x & y;
        p_s  = x ^ y;
        gg_s = 4'd0;
        gp_s = 4'd0;
        for (int k = 0; k < 4; k++) begin
            gp_s[k] = &p_s[4*k +: 4];
            gg_s[k] = g_s[4*k+3]
                    | (p_s[4*k+3] & g_s[4*k+2])
                    | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
        end
        gc_s[0] = cin;
        gc_s[1] = gg_s[0] | (gp_s[0] & cin);
        gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & cin);
        gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[2] & gp_s[1] & gp_s[0] & cin);
        gc_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & cin);
        c_s = {(MULT_W+1){1'b0}};
        for (int k = 0; k < 4; k++) begin
            c_s[4*k] = gc_s[k];
            for (int j = 0; j < 3; j++) begin
                c_s[4*k+j+1] = g_s[4*k+j] | (p_s[4*k+j] & c_s[4*k+j]);
            end
        end
        c_s[MULT_W] = gc_s[4];
        sum  = p_s ^ c_s[MULT_W-1:0];
        cout = c_s[MULT_W];
    end

endmodule

// File: rtl/mult_ctrl.sv
// FSM and iteration counter for mult_16_seq. Emits load (request accepted),
// step (one shift-add pass), fix (sign correction, MULT_SIGNED_EN only) and
// done (result is captured this edge) strobes.
module mult_ctrl
    import mult_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
`ifdef MULT_SIGNED_EN
    input  logic neg,
    output logic fix,
`endif
    output logic load,
    output logic step,
    output logic done
);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state, counter update and strobe decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        load    = 1'b0;
        step    = 1'b0;
        done    = 1'b0;
`ifdef MULT_SIGNED_EN
        fix     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_s   = ITER_LAST;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_r == {CNT_W{1'b0}}) begin
`ifdef MULT_SIGNED_EN
                    if (neg) begin
                        state_s = FIX;
                    end else begin
                        state_s = DONE;
                        done    = 1'b1;
                    end
`else
                    state_s = DONE;
                    done    = 1'b1;
`endif
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            FIX: begin
`ifdef MULT_SIGNED_EN
                fix     = 1'b1;
                done    = 1'b1;
                state_s = DONE;
`else
                // Unreachable without signed support; recover to IDLE.
                state_s = IDLE;
`endif
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/mult_16_seq.sv
// Iterative 16x16 shift-add multiplier producing a 32-bit product as HI/LO.
// One adder pass per cycle for 16 cycles; result registered on entry to DONE.
// Optional signed mode (MULT_SIGNED_EN): multiplies magnitudes, then negates
// the product in an extra FIX cycle when the operand signs differ.
module mult_16_seq
    import mult_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mult_16_seq_if.slave       bus
);

    logic [MULT_W-1:0]   acc_r;
    logic [MULT_W-1:0]   mcand_r;
    logic [MULT_W-1:0]   mplr_r;
    logic                busy_r;
    logic                done_r;
    logic [MULT_W-1:0]   hi_r;
    logic [MULT_W-1:0]   lo_r;

    logic                load_s;
    logic                step_s;
    logic                done_s;
    logic [MULT_W-1:0]   a_op_s;
    logic [MULT_W-1:0]   b_op_s;
    logic [MULT_W-1:0]   add_y_s;
    logic [MULT_W-1:0]   sum_s;
    logic                cout_s;
    logic [2*MULT_W-1:0] prod_next_s;

`ifdef MULT_SIGNED_EN
    logic                neg_r;
    logic                neg_in_s;
    logic                fix_s;

    // Signed requests run on magnitudes; the sign is applied in FIX.
    always_comb begin
        if (bus.is_signed) begin
            a_op_s   = abs_w(bus.a);
            b_op_s   = abs_w(bus.b);
            neg_in_s = bus.a[MULT_W-1] ^ bus.b[MULT_W-1];
        end else begin
            a_op_s   = bus.a;
            b_op_s   = bus.b;
            neg_in_s = 1'b0;
        end
    end

    // Result sign, captured with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_r <= 1'b0;
        end else if (load_s) begin
            neg_r <= neg_in_s;
        end else begin
            neg_r <= neg_r;
        end
    end
`else
    // Operands are always unsigned.
    always_comb begin
        a_op_s = bus.a;
        b_op_s = bus.b;
    end
`endif

    mult_ctrl u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bus.start),
`ifdef MULT_SIGNED_EN
        .neg   (neg_r),
        .fix   (fix_s),
`endif
        .load  (load_s),
        .step  (step_s),
        .done  (done_s)
    );

    // Add the multiplicand only when the current multiplier LSB is set.
    always_comb begin
        if (mplr_r[0]) begin
            add_y_s = mcand_r;
        end else begin
            add_y_s = {MULT_W{1'b0}};
        end
    end

    cla_add16 u_add (
        .x    (acc_r),
        .y    (add_y_s),
        .cin  (1'b0),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // {acc, mplr} after this pass: 17-bit sum shifted right with the multiplier.
    always_comb begin
        prod_next_s = {cout_s, sum_s, mplr_r[MULT_W-1:1]};
    end

    // Partial-product datapath: load on accept, shift-add on each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= {MULT_W{1'b0}};
            mcand_r <= {MULT_W{1'b0}};
            mplr_r  <= {MULT_W{1'b0}};
        end else if (load_s) begin
            acc_r   <= {MULT_W{1'b0}};
            mcand_r <= a_op_s;
            mplr_r  <= b_op_s;
        end else if (step_s) begin
            acc_r   <= prod_next_s[2*MULT_W-1:MULT_W];
            mplr_r  <= prod_next_s[MULT_W-1:0];
        end else begin
            acc_r   <= acc_r;
            mplr_r  <= mplr_r;
        end
    end

    // Handshake status: busy from accept until the result is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (load_s) begin
                busy_r <= 1'b1;
            end else if (done_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            done_r <= done_s;
        end
    end

    // Result registers; they change only when entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= {MULT_W{1'b0}};
            lo_r <= {MULT_W{1'b0}};
`ifdef MULT_SIGNED_EN
        end else if (fix_s) begin
            {hi_r, lo_r} <= neg_2w({acc_r, mplr_r});
`endif
        end else if (done_s) begin
            {hi_r, lo_r} <= prod_next_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mult_16_seq.sv
// Self-checking bench for mult_16_seq: directed and random products against
// an arithmetic reference model, handshake timing, and reset behaviour.
module tb_mult_16_seq;

`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;

    mult_16_seq_if bus();

    mult_16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference product computed with plain integer arithmetic.
    function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                             input logic sgn);
        int sx;
        int sy;
        if (SIGNED_EN && sgn) begin
            sx = $signed(x);
            sy = $signed(y);
            return 32'(sx * sy);
        end else begin
            return {16'd0, x} * {16'd0, y};
        end
    endfunction

    // Expected accept-to-done latency in cycles.
    function automatic int ref_lat(input logic [15:0] x, input logic [15:0] y,
                                   input logic sgn);
        if (SIGNED_EN && sgn && (x[15] ^ y[15])) return 18;
        else return 17;
    endfunction

    // Issue one request and observe it until done (bounded).
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic sgn,
                          output logic [15:0] h, output logic [15:0] l, output int lat,
                          output logic busy_first, output logic busy_at_done,
                          output logic held, output logic timed_out);
        logic [15:0] h0;
        logic [15:0] l0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = x;
        bus.b = y;
        bus.is_signed = sgn;
        h0 = bus.hi;
        l0 = bus.lo;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        lat = 1;
        busy_first = bus.busy;
        held = 1'b1;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        timed_out = (bus.done !== 1'b1);
        h = bus.hi;
        l = bus.lo;
        busy_at_done = bus.busy;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.a = 16'd0;
        bus.b = 16'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
        checks++; if (bus.hi !== 16'h0) $display("FAIL reset_hi: got %h want 0000", bus.hi); else passed++;
        checks++; if (bus.lo !== 16'h0) $display("FAIL reset_lo: got %h want 0000", bus.lo); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_directed();
        logic [15:0] h, l;
        int lat;
        logic bf, bd, hd, to;
        run_op(16'h0003, 16'h0005, 1'b0, h, l, lat, bf, bd, hd, to);
        checks++; if (to !== 1'b0) $display("FAIL d3x5_timeout: got %b want 0", to); else passed++;
        checks++; if (lat !== 17) $display("FAIL d3x5_latency: got %0d want 17", lat); else passed++;
        checks++; if (bf !== 1'b1) $display("FAIL d3x5_busy_first: got %b want 1", bf); else passed++;
        checks++; if (bd !== 1'b0) $display("FAIL d3x5_busy_in_done: got %b want 0", bd); else passed++;
        checks++; if (h !== 16'h0000) $display("FAIL d3x5_hi: got %h want 0000", h); else passed++;
        checks++; if (l !== 16'h000F) $display("FAIL d3x5_lo: got %h want 000f", l); else passed++;
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) $display("FAIL d3x5_done_pulse: got %b want 0", bus.done); else passed++;
        run_op(16'hFFFF, 16'hFFFF, 1'b0, h, l, lat, bf, bd, hd, to);
        checks++; if (h !== 16'hFFFE) $display("FAIL dffff_hi: got %h want fffe", h); else passed++;
        checks++; if (l !== 16'h0001) $display("FAIL dffff_lo: got %h want 0001", l); else passed++;
        checks++; if (lat !== 17) $display("FAIL dffff_latency: got %0d want 17", lat); else passed++;
    endtask

    task automatic test_random();
        logic [15:0] h, l, x, y;
        logic sgn, bf, bd, hd, to;
        int lat;
        for (int i = 0; i < 16; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            sgn = 1'($urandom);
            run_op(x, y, sgn, h, l, lat, bf, bd, hd, to);
            checks++;
            if ({h, l} !== ref_prod(x, y, sgn))
                $display("FAIL rand_prod[%0d] %h*%h s=%b: got %h want %h", i, x, y, sgn, {h, l}, ref_prod(x, y, sgn));
            else passed++;
            checks++;
            if (lat !== ref_lat(x, y, sgn))
                $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, ref_lat(x, y, sgn));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] h, l;
        int lat;
        logic bf, bd, hd, to;
        run_op(16'h0000, 16'h1234, 1'b0, h, l, lat, bf, bd, hd, to);
        checks++; if (l !== 16'h0000) $display("FAIL b2b1_lo: got %h want 0000", l); else passed++;
        checks++; if (h !== 16'h0000) $display("FAIL b2b1_hi: got %h want 0000", h); else passed++;
        run_op(16'h1234, 16'h0001, 1'b0, h, l, lat, bf, bd, hd, to);
        checks++; if (hd !== 1'b1) $display("FAIL b2b2_hilo_held: got %b want 1", hd); else passed++;
        checks++; if (lat !== 17) $display("FAIL b2b2_latency: got %0d want 17", lat); else passed++;
        checks++; if (l !== 16'h1234) $display("FAIL b2b2_lo: got %h want 1234", l); else passed++;
        checks++; if (h !== 16'h0000) $display("FAIL b2b2_hi: got %h want 0000", h); else passed++;
        // start raised during the DONE cycle must be ignored
        bus.start = 1'b1;
        bus.a = 16'h00FF;
        bus.b = 16'h00FF;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) $display("FAIL done_start_ignored: got busy %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_start_while_busy();
        int n;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'h00C3;
        bus.b = 16'h0101;
        bus.is_signed = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (bus.done !== 1'b1 && n < 40) begin
            if (n == 5) begin
                bus.start = 1'b1;
                bus.a = 16'hFFFF;
                bus.b = 16'hFFFF;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        checks++; if (n !== 17) $display("FAIL busy_start_latency: got %0d want 17", n); else passed++;
        checks++; if ({bus.hi, bus.lo} !== ref_prod(16'h00C3, 16'h0101, 1'b0))
            $display("FAIL busy_start_prod: got %h want %h", {bus.hi, bus.lo}, ref_prod(16'h00C3, 16'h0101, 1'b0));
        else passed++;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) $display("FAIL busy_start_no_relaunch: got %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] h, l;
        int lat;
        logic bf, bd, hd, to, saw_done;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = 16'h1111;
        bus.b = 16'h2222;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL midrst_done: got %b want 0", bus.done); else passed++;
        checks++; if (bus.hi !== 16'h0) $display("FAIL midrst_hi: got %h want 0000", bus.hi); else passed++;
        checks++; if (bus.lo !== 16'h0) $display("FAIL midrst_lo: got %h want 0000", bus.lo); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) $display("FAIL midrst_no_activity: got %b want 0", saw_done); else passed++;
        run_op(16'h0102, 16'h0304, 1'b0, h, l, lat, bf, bd, hd, to);
        checks++; if ({h, l} !== ref_prod(16'h0102, 16'h0304, 1'b0))
            $display("FAIL midrst_next_prod: got %h want %h", {h, l}, ref_prod(16'h0102, 16'h0304, 1'b0));
        else passed++;
        checks++; if (lat !== 17) $display("FAIL midrst_next_latency: got %0d want 17", lat); else passed++;
    endtask

    task automatic test_signed();
        logic [15:0] h, l;
        int lat;
        logic bf, bd, hd, to;
        run_op(16'hFFFE, 16'h0003, 1'b1, h, l, lat, bf, bd, hd, to);
`ifdef MULT_SIGNED_EN
        checks++; if (h !== 16'hFFFF) $display("FAIL sgn_neg_hi: got %h want ffff", h); else passed++;
        checks++; if (l !== 16'hFFFA) $display("FAIL sgn_neg_lo: got %h want fffa", l); else passed++;
        checks++; if (lat !== 18) $display("FAIL sgn_neg_latency: got %0d want 18", lat); else passed++;
        checks++; if (bd !== 1'b0) $display("FAIL sgn_neg_busy_in_done: got %b want 0", bd); else passed++;
        run_op(16'h8000, 16'h8000, 1'b1, h, l, lat, bf, bd, hd, to);
        checks++; if (h !== 16'h4000) $display("FAIL sgn_min_hi: got %h want 4000", h); else passed++;
        checks++; if (l !== 16'h0000) $display("FAIL sgn_min_lo: got %h want 0000", l); else passed++;
        checks++; if (lat !== 17) $display("FAIL sgn_min_latency: got %0d want 17", lat); else passed++;
`else
        checks++; if (h !== 16'h0002) $display("FAIL sgn_ignored_hi: got %h want 0002", h); else passed++;
        checks++; if (l !== 16'hFFFA) $display("FAIL sgn_ignored_lo: got %h want fffa", l); else passed++;
        checks++; if (lat !== 17) $display("FAIL sgn_ignored_latency: got %0d want 17", lat); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid();
        test_signed();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
